// File: rtl/mem_port_arbiter.sv
// Single-port memory bus arbiter between fetch (imem) and load/store (dmem) ports.
// Optional imem anti-starvation streak limit: define MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DMEM_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                imem_req,
  input  logic [ADDR_W-1:0]   imem_addr,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_wait,
  input  logic                dmem_req,
  input  logic                dmem_we,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W/8-1:0] dmem_wstrb,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_wait,
  output logic                bus_valid,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ready
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned STREAK_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;

  // Streak limit must fit the 4-bit counter and be non-zero.
  if (MAX_DMEM_STREAK < 1 || MAX_DMEM_STREAK > 15) begin : g_bad_streak
    $error("mem_port_arbiter: MAX_DMEM_STREAK out of range 1..15");
  end

  logic [1:0]        state_q,     state_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_we_q,    bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0] bus_wstrb_q, bus_wstrb_d;
  logic              pick_d_c;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DMEM_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;

  // dmem keeps priority until it has starved a waiting fetch STREAK_MAX times.
  assign pick_d_c = dmem_req & ~(imem_req & (streak_q == STREAK_MAX));

  always_comb begin
    streak_d = streak_q;
    if (state_q == ST_IDLE) begin
      if (pick_d_c) begin
        if (imem_req && (streak_q != STREAK_MAX)) begin
          streak_d = streak_q + STREAK_W'(1);
        end
      end else if (imem_req) begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign pick_d_c = dmem_req;
`endif

  // Grant FSM: bus registers are loaded exactly once, on the IDLE->GNT transition.
  always_comb begin
    state_d     = state_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    case (state_q)
      ST_IDLE: begin
        bus_valid_d = 1'b0;
        if (pick_d_c) begin
          state_d     = ST_GNT_D;
          bus_valid_d = 1'b1;
          bus_we_d    = dmem_we;
          bus_addr_d  = dmem_addr;
          bus_wdata_d = dmem_wdata;
          bus_wstrb_d = dmem_wstrb;
        end else if (imem_req) begin
          state_d     = ST_GNT_I;
          bus_valid_d = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = imem_addr;
          bus_wdata_d = '0;
          bus_wstrb_d = '0;
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        // No abort: a dropped request still runs to bus_ready.
        if (bus_ready) begin
          state_d     = ST_IDLE;
          bus_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
    end
  end

  // Stalls release in the completing cycle so the pipeline advances with the data.
  assign imem_wait  = imem_req & ~((state_q == ST_GNT_I) & bus_ready);
  assign dmem_wait  = dmem_req & ~((state_q == ST_GNT_D) & bus_ready);
  assign imem_rdata = bus_rdata;
  assign dmem_rdata = bus_rdata;

  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expected grant order follows MEM_ARB_FAIRNESS_EN.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              clk;
  logic              rst_n;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_wait;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [STRB_W-1:0] dmem_wstrb;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_wait;
  logic              bus_valid;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [STRB_W-1:0] bus_wstrb;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ready;

  int checks;
  int failures;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DMEM_STREAK(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_wait(imem_wait),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_wait(dmem_wait),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_is_i;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    imem_req  = 1'b0;
    imem_addr = '0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    dmem_addr = '0;
    dmem_wdata = '0;
    dmem_wstrb = '0;
    bus_rdata = '0;
    bus_ready = 1'b0;

    // Reset state
    repeat (3) step();
    sample();
    check("rst_bus_valid", 64'(bus_valid), 64'd0);
    check("rst_bus_addr",  64'(bus_addr),  64'd0);
    check("rst_imem_wait", 64'(imem_wait), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single fetch with immediate ready
    imem_req  = 1'b1;
    imem_addr = 32'h100;
    sample();
    check("fetch_wait_n",  64'(imem_wait), 64'd1);
    check("fetch_valid_n", 64'(bus_valid), 64'd0);
    step();
    bus_ready = 1'b1;
    bus_rdata = 32'h0000_0013;
    sample();
    check("fetch_valid",  64'(bus_valid),  64'd1);
    check("fetch_addr",   64'(bus_addr),   64'h100);
    check("fetch_we",     64'(bus_we),     64'd0);
    check("fetch_wait",   64'(imem_wait),  64'd0);
    check("fetch_rdata",  64'(imem_rdata), 64'h13);
    step();
    imem_req  = 1'b0;
    bus_ready = 1'b0;
    sample();
    check("fetch_idle", 64'(bus_valid), 64'd0);
    step();

    // Simultaneous store and fetch: store first, fetch after one idle cycle
    imem_req   = 1'b1;
    imem_addr  = 32'h104;
    dmem_req   = 1'b1;
    dmem_we    = 1'b1;
    dmem_addr  = 32'h2000;
    dmem_wdata = 32'hDEAD_BEEF;
    dmem_wstrb = 4'hF;
    sample();
    check("both_dwait_n", 64'(dmem_wait), 64'd1);
    check("both_iwait_n", 64'(imem_wait), 64'd1);
    step();
    bus_ready = 1'b1;
    sample();
    check("st_valid", 64'(bus_valid), 64'd1);
    check("st_we",    64'(bus_we),    64'd1);
    check("st_addr",  64'(bus_addr),  64'h2000);
    check("st_wdata", 64'(bus_wdata), 64'hDEAD_BEEF);
    check("st_wstrb", 64'(bus_wstrb), 64'hF);
    check("st_dwait", 64'(dmem_wait), 64'd0);
    check("st_iwait", 64'(imem_wait), 64'd1);
    step();
    dmem_req  = 1'b0;
    bus_ready = 1'b0;
    sample();
    check("gap_valid", 64'(bus_valid), 64'd0);
    check("gap_iwait", 64'(imem_wait), 64'd1);
    step();
    bus_ready = 1'b1;
    sample();
    check("f2_valid", 64'(bus_valid), 64'd1);
    check("f2_we",    64'(bus_we),    64'd0);
    check("f2_addr",  64'(bus_addr),  64'h104);
    check("f2_wstrb", 64'(bus_wstrb), 64'h0);
    check("f2_iwait", 64'(imem_wait), 64'd0);
    step();
    imem_req  = 1'b0;
    bus_ready = 1'b0;
    step();

    // Load with ready delayed three cycles
    dmem_req  = 1'b1;
    dmem_we   = 1'b0;
    dmem_addr = 32'h3000;
    sample();
    check("ld_wait0", 64'(dmem_wait), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      step();
      sample();
      check("ld_hold_valid", 64'(bus_valid), 64'd1);
      check("ld_hold_addr",  64'(bus_addr),  64'h3000);
      check("ld_hold_we",    64'(bus_we),    64'd0);
      check("ld_hold_wait",  64'(dmem_wait), 64'd1);
    end
    step();
    bus_ready = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    sample();
    check("ld_done_wait",  64'(dmem_wait),  64'd0);
    check("ld_done_rdata", 64'(dmem_rdata), 64'hCAFE_F00D);
    check("ld_done_addr",  64'(bus_addr),   64'h3000);
    step();
    dmem_req  = 1'b0;
    bus_ready = 1'b0;
    sample();
    check("ld_idle", 64'(bus_valid), 64'd0);
    step();

    // Fetch dropped mid-grant runs to completion without a new grant
    imem_req  = 1'b1;
    imem_addr = 32'h200;
    step();
    imem_req = 1'b0;
    sample();
    check("drop_valid", 64'(bus_valid), 64'd1);
    check("drop_addr",  64'(bus_addr),  64'h200);
    check("drop_wait",  64'(imem_wait), 64'd0);
    step();
    bus_ready = 1'b1;
    sample();
    check("drop_still_valid", 64'(bus_valid), 64'd1);
    step();
    bus_ready = 1'b0;
    sample();
    check("drop_idle0", 64'(bus_valid), 64'd0);
    step();
    sample();
    check("drop_idle1", 64'(bus_valid), 64'd0);

    // bus_ready while idle is ignored
    bus_ready = 1'b1;
    step();
    sample();
    check("idle_ready", 64'(bus_valid), 64'd0);
    bus_ready = 1'b0;
    step();

    // Continuous dmem and imem traffic: grant order
    dmem_req  = 1'b1;
    dmem_we   = 1'b0;
    dmem_addr = 32'h4000;
    imem_req  = 1'b1;
    imem_addr = 32'h300;
    bus_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
`ifdef MEM_ARB_FAIRNESS_EN
      exp_is_i = (g == 4);
`else
      exp_is_i = 1'b0;
`endif
      exp_addr = exp_is_i ? 32'h300 : 32'h4000;
      step();
      sample();
      check("fair_valid", 64'(bus_valid), 64'd1);
      check("fair_addr",  64'(bus_addr),  64'(exp_addr));
      check("fair_iwait", 64'(imem_wait), 64'(!exp_is_i));
      check("fair_dwait", 64'(dmem_wait), 64'(exp_is_i));
      step();
    end
    dmem_req  = 1'b0;
    imem_req  = 1'b0;
    bus_ready = 1'b0;
    step();

    // Reset asserted mid store grant
    dmem_req   = 1'b1;
    dmem_we    = 1'b1;
    dmem_addr  = 32'h5000;
    dmem_wdata = 32'h1234_5678;
    dmem_wstrb = 4'h3;
    step();
    sample();
    check("rstmid_pre_valid", 64'(bus_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", 64'(bus_valid), 64'd0);
    check("rstmid_we",    64'(bus_we),    64'd0);
    check("rstmid_addr",  64'(bus_addr),  64'd0);
    check("rstmid_wdata", 64'(bus_wdata), 64'd0);
    check("rstmid_wstrb", 64'(bus_wstrb), 64'd0);
    dmem_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    sample();
    check("rstmid_idle", 64'(bus_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
